// File: rtl/mips_mc_core.sv
// Multicycle MIPS-subset core: datapath, control FSM and one shared memory port.
// The memory port uses a ready/valid handshake. Unsupported opcodes trap sticky.
// Optional build macro: MIPS_MC_PERF_EN adds the cycle and retire counters cyc_cnt and ret_cnt.
module mips_mc_core #(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned REG_ZERO = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              illegal
`ifdef MIPS_MC_PERF_EN
    ,
    output logic [31:0]       cyc_cnt,
    output logic [31:0]       ret_cnt
`endif
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_ILL
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc_n;
    logic [31:0]       ir, ir_n, a, a_n, b, b_n, aluout, aluout_n, mdr, mdr_n;
    logic [31:0]       rf [32];
    logic              rf_we;
    logic [4:0]        rf_wa;
    logic [31:0]       rf_wd;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] signimm, pc32, jt, rf_a, rf_b, diff;
    logic        accept;
    logic        unused_bits;

    assign op      = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign funct   = ir[5:0];
    assign signimm = {{16{ir[15]}}, ir[15:0]};
    assign pc32    = 32'(pc);
    assign jt      = {pc32[31:28], ir[25:0], 2'b00};
    assign diff    = a - b;
    assign accept  = mem_req & mem_ready;
    assign rf_a    = (REG_ZERO != 0 && rs == 5'd0) ? 32'd0 : rf[rs];
    assign rf_b    = (REG_ZERO != 0 && rt == 5'd0) ? 32'd0 : rf[rt];
    assign unused_bits = ^{ir[10:6], jt};

    // Next-state, datapath next values and register-file write control
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        ir_n     = ir;
        a_n      = a;
        b_n      = b;
        aluout_n = aluout;
        mdr_n    = mdr;
        rf_we    = 1'b0;
        rf_wa    = rt;
        rf_wd    = aluout;
        case (state)
            S_FETCH: if (accept) begin
                ir_n    = mem_rdata;
                pc_n    = pc + ADDR_W'(4);
                state_n = S_DECODE;
            end
            S_DECODE: begin
                a_n      = rf_a;
                b_n      = rf_b;
                aluout_n = pc32 + {signimm[29:0], 2'b00};
                case (op)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_R:         state_n = S_EXEC;
                    OP_BEQ:       state_n = S_BRANCH;
                    OP_ADDI:      state_n = S_ADDIEX;
                    OP_J:         state_n = S_JUMP;
                    default:      state_n = S_ILL;
                endcase
            end
            S_MEMADR: begin
                aluout_n = a + signimm;
                state_n  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: if (accept) begin
                mdr_n   = mem_rdata;
                state_n = S_MEMWB;
            end
            S_MEMWB: begin
                rf_we   = 1'b1;
                rf_wd   = mdr;
                state_n = S_FETCH;
            end
            S_MEMWR: if (accept) state_n = S_FETCH;
            S_EXEC: begin
                state_n = S_ALUWB;
                case (funct)
                    6'h20:   aluout_n = a + b;
                    6'h22:   aluout_n = diff;
                    6'h24:   aluout_n = a & b;
                    6'h25:   aluout_n = a | b;
                    6'h2A:   aluout_n = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: state_n  = S_ILL;
                endcase
            end
            S_ALUWB: begin
                rf_we   = 1'b1;
                rf_wa   = rd;
                state_n = S_FETCH;
            end
            S_ADDIEX: begin
                aluout_n = a + signimm;
                state_n  = S_ADDIWB;
            end
            S_ADDIWB: begin
                rf_we   = 1'b1;
                state_n = S_FETCH;
            end
            S_BRANCH: begin
                if (diff == 32'd0) pc_n = aluout[ADDR_W-1:0];
                state_n = S_FETCH;
            end
            S_JUMP: begin
                pc_n    = jt[ADDR_W-1:0];
                state_n = S_FETCH;
            end
            S_ILL:   state_n = S_ILL;
            default: state_n = S_FETCH;
        endcase
    end

    // State, datapath latches and registered memory-port outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_FETCH;
            pc        <= ADDR_W'(RESET_PC);
            ir        <= 32'd0;
            a         <= 32'd0;
            b         <= 32'd0;
            aluout    <= 32'd0;
            mdr       <= 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_adr   <= ADDR_W'(RESET_PC);
            mem_wdata <= 32'd0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            ir        <= ir_n;
            a         <= a_n;
            b         <= b_n;
            aluout    <= aluout_n;
            mdr       <= mdr_n;
            mem_req   <= (state_n == S_FETCH) || (state_n == S_MEMRD) || (state_n == S_MEMWR);
            mem_we    <= (state_n == S_MEMWR);
            mem_adr   <= (state_n == S_FETCH) ? pc_n : aluout_n[ADDR_W-1:0];
            mem_wdata <= b_n;
            illegal   <= illegal | (state_n == S_ILL);
        end
    end

    // Register file write port (not reset)
    always_ff @(posedge clk) begin
        if (rf_we && !(REG_ZERO != 0 && rf_wa == 5'd0)) rf[rf_wa] <= rf_wd;
    end

`ifdef MIPS_MC_PERF_EN
    // Free-running cycle counter and retired-instruction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_cnt <= 32'd0;
            ret_cnt <= 32'd0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (state != S_FETCH && state_n == S_FETCH) ret_cnt <= ret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_mc_core.sv
// Self-checking bench for mips_mc_core: word memory model with programmable
// wait states, store scoreboard, instruction cycle and pc-sequence checks.
module tb_mips_mc_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ready, illegal;
    logic [31:0] mem_adr, mem_wdata, mem_rdata, pc;
`ifdef MIPS_MC_PERF_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    mips_mc_core #(.ADDR_W(32), .RESET_PC(32'h100), .REG_ZERO(1)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .illegal(illegal)
`ifdef MIPS_MC_PERF_EN
        , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
    } st_t;

    st_t         exp_st[$];
    logic [31:0] wlog_adr[$];
    logic [31:0] wlog_dat[$];
    logic [31:0] mem [0:1023];
    int          checks = 0;
    int          errors = 0;
    int          wait_cfg = 0;
    int          wcnt = 0;
    int          ncyc = 0;
    logic        acc_fetch = 1'b0;
    logic [31:0] acc_adr = 32'd0;

    localparam logic [31:0] ILL_OP = 32'hFC000000;

    task automatic put(input logic [31:0] adr, input logic [31:0] w);
        mem[adr[11:2]] = w;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        exp_st.delete();
        wlog_adr.delete();
        wlog_dat.delete();
    endtask

    task automatic expect_store(input logic [31:0] adr, input logic [31:0] data);
        st_t e;
        e.adr  = adr;
        e.data = data;
        exp_st.push_back(e);
    endtask

    // One clock: respond to the current request, then advance to the next negedge
    task automatic step();
        st_t e;
        acc_fetch = 1'b0;
        if (mem_req) begin
            mem_rdata = mem[mem_adr[11:2]];
            if (mem_we) begin
                wlog_adr.push_back(mem_adr);
                wlog_dat.push_back(mem_wdata);
            end
            if (wcnt >= wait_cfg) begin
                mem_ready = 1'b1;
                wcnt = 0;
                if (mem_we) begin
                    mem[mem_adr[11:2]] = mem_wdata;
                    checks++;
                    if (exp_st.size() == 0) begin
                        errors++;
                        $display("FAIL store_unexpected adr=%h data=%h", mem_adr, mem_wdata);
                    end else begin
                        e = exp_st.pop_front();
                        if (mem_adr !== e.adr || mem_wdata !== e.data) begin
                            errors++;
                            $display("FAIL store got adr=%h data=%h exp adr=%h data=%h",
                                     mem_adr, mem_wdata, e.adr, e.data);
                        end
                    end
                end else if (mem_adr == pc) begin
                    acc_fetch = 1'b1;
                    acc_adr = mem_adr;
                end
            end else begin
                mem_ready = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ready = 1'b0;
            mem_rdata = 32'hDEADBEEF;
        end
        @(negedge clk);
        ncyc++;
    endtask

    // Run until the next accepted instruction fetch; n = cycles since the previous one
    task automatic next_instr(output int n, output logic [31:0] a);
        n = 0;
        a = 32'hFFFFFFFF;
        do begin
            step();
            n++;
        end while (!acc_fetch && n < 200);
        if (!acc_fetch) begin
            checks++;
            errors++;
            $display("FAIL next_instr_timeout after %0d cycles", n);
        end else begin
            a = acc_adr;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        wcnt = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ncyc = 0;
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_st.size() != 0) begin
            errors++;
            $display("FAIL %s_pending_stores got %0d exp 0", name, exp_st.size());
        end
    endtask

    task automatic test_reset();
        clear_mem();
        put(32'h100, 32'h20010005);
        reset = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", mem_we); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b exp 0", illegal); end
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL rst_pc got %h exp 100", pc); end
        @(negedge clk);
        reset = 1'b0;
        ncyc = 0;
        step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", mem_req); end
        checks++; if (mem_adr !== 32'h100) begin errors++; $display("FAIL first_adr got %h exp 100", mem_adr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL first_we got %b exp 0", mem_we); end
    endtask

    task automatic test_alu_mem();
        int          len [14] = '{4, 4, 4, 4, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4};
        logic [31:0] prog [15] = '{32'h20010005, 32'h20020007, 32'h00221820, 32'hAC030008,
                                   32'h8C040008, 32'hAC04000C, 32'h00222822, 32'hAC050010,
                                   32'h00223024, 32'h00223825, 32'h00A1402A, 32'hAC060014,
                                   32'hAC070018, 32'hAC08001C, ILL_OP};
        int          n;
        logic [31:0] a;
        clear_mem();
        for (int i = 0; i < 15; i++) put(32'h100 + 32'(4 * i), prog[i]);
        expect_store(32'd8,  32'd12);
        expect_store(32'd12, 32'd12);
        expect_store(32'd16, 32'hFFFFFFFE);
        expect_store(32'd20, 32'd5);
        expect_store(32'd24, 32'd7);
        expect_store(32'd28, 32'd1);
        wait_cfg = 0;
        do_reset();
        next_instr(n, a);
        checks++; if (a !== 32'h100) begin errors++; $display("FAIL alu_first_fetch got %h exp 100", a); end
        for (int i = 1; i <= 14; i++) begin
            next_instr(n, a);
            checks++;
            if (n != len[i-1]) begin errors++; $display("FAIL alu_cycles[%0d] got %0d exp %0d", i - 1, n, len[i-1]); end
            checks++;
            if (a !== 32'h100 + 32'(4 * i)) begin
                errors++; $display("FAIL alu_pc[%0d] got %h exp %h", i, a, 32'h100 + 32'(4 * i));
            end
        end
        repeat (4) step();
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL alu_end_illegal got %b exp 1", illegal); end
        check_queue_empty("alu");
    endtask

    task automatic test_wait_states();
        int          len [4] = '{7, 10, 11, 10};
        int          n;
        logic [31:0] a;
        clear_mem();
        put(32'h100, 32'h2003000C);
        put(32'h104, 32'hAC030008);
        put(32'h108, 32'h8C040008);
        put(32'h10C, 32'hAC04000C);
        put(32'h110, ILL_OP);
        expect_store(32'd8,  32'd12);
        expect_store(32'd12, 32'd12);
        wait_cfg = 3;
        do_reset();
        next_instr(n, a);
        for (int i = 1; i <= 4; i++) begin
            next_instr(n, a);
            checks++;
            if (n != len[i-1]) begin errors++; $display("FAIL wait_cycles[%0d] got %0d exp %0d", i - 1, n, len[i-1]); end
            checks++;
            if (a !== 32'h100 + 32'(4 * i)) begin
                errors++; $display("FAIL wait_pc[%0d] got %h exp %h", i, a, 32'h100 + 32'(4 * i));
            end
        end
        checks++;
        if (wlog_adr.size() != 8) begin
            errors++; $display("FAIL wait_wr_cycles got %0d exp 8", wlog_adr.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wlog_adr[i] !== ((i < 4) ? 32'd8 : 32'd12) || wlog_dat[i] !== 32'd12) begin
                    errors++;
                    $display("FAIL wait_wr_hold[%0d] got adr=%h data=%h exp adr=%h data=0000000c",
                             i, wlog_adr[i], wlog_dat[i], (i < 4) ? 32'd8 : 32'd12);
                end
            end
        end
        check_queue_empty("wait");
        wait_cfg = 0;
    endtask

    task automatic test_branch();
        int          len [5] = '{4, 4, 3, 3, 3};
        logic [31:0] adr [6] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h10C, 32'h10C};
        int          n;
        logic [31:0] a;
        clear_mem();
        put(32'h100, 32'h20010005);
        put(32'h104, 32'h20020007);
        put(32'h108, 32'h10220005);
        put(32'h10C, 32'h1021FFFF);
        do_reset();
        next_instr(n, a);
        for (int i = 1; i < 6; i++) begin
            next_instr(n, a);
            checks++;
            if (n != len[i-1]) begin errors++; $display("FAIL br_cycles[%0d] got %0d exp %0d", i - 1, n, len[i-1]); end
            checks++;
            if (a !== adr[i]) begin errors++; $display("FAIL br_pc[%0d] got %h exp %h", i, a, adr[i]); end
        end
    endtask

    task automatic test_jump();
        logic [31:0] adr [3] = '{32'h100, 32'h40, 32'h100};
        int          n;
        logic [31:0] a;
        clear_mem();
        put(32'h100, 32'h08000010);
        put(32'h040, 32'h08000040);
        do_reset();
        next_instr(n, a);
        for (int i = 1; i < 3; i++) begin
            next_instr(n, a);
            checks++;
            if (n != 3) begin errors++; $display("FAIL j_cycles[%0d] got %0d exp 3", i, n); end
            checks++;
            if (a !== adr[i]) begin errors++; $display("FAIL j_pc[%0d] got %h exp %h", i, a, adr[i]); end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] word [2] = '{ILL_OP, 32'h00221821};
        int          n;
        int          req_seen;
        logic [31:0] a;
        for (int k = 0; k < 2; k++) begin
            clear_mem();
            put(32'h100, word[k]);
            do_reset();
            checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_clear[%0d] got %b exp 0", k, illegal); end
            next_instr(n, a);
            req_seen = 0;
            repeat (20) begin
                step();
                if (mem_req) req_seen++;
            end
            checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_flag[%0d] got %b exp 1", k, illegal); end
            checks++; if (req_seen != 0) begin errors++; $display("FAIL ill_req[%0d] got %0d exp 0", k, req_seen); end
            checks++; if (pc !== 32'h104) begin errors++; $display("FAIL ill_pc[%0d] got %h exp 104", k, pc); end
        end
    endtask

    task automatic test_reset_mid_access();
        int          n;
        logic [31:0] a;
        clear_mem();
        put(32'h100, 32'h8C040008);
        wait_cfg = 5;
        do_reset();
        n = 0;
        while (!(mem_req && mem_adr == 32'd8) && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (!(mem_req && mem_adr == 32'd8)) begin
            errors++; $display("FAIL mid_memrd_reach got req=%b adr=%h exp req=1 adr=8", mem_req, mem_adr);
        end
        #2 reset = 1'b1;
        mem_ready = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_req got %b exp 0", mem_req); end
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL mid_pc got %h exp 100", pc); end
        @(negedge clk);
        reset = 1'b0;
        wcnt = 0;
        wait_cfg = 0;
        next_instr(n, a);
        checks++; if (a !== 32'h100) begin errors++; $display("FAIL mid_refetch got %h exp 100", a); end
    endtask

`ifdef MIPS_MC_PERF_EN
    task automatic test_perf();
        int          n;
        logic [31:0] a;
        clear_mem();
        put(32'h100, 32'h20010001);
        put(32'h104, 32'h20020002);
        put(32'h108, 32'h20030003);
        put(32'h10C, ILL_OP);
        do_reset();
        checks++; if (ret_cnt !== 32'd0) begin errors++; $display("FAIL perf_ret_rst got %0d exp 0", ret_cnt); end
        n = 0;
        a = 32'd0;
        while (a != 32'h10C && n < 10) begin
            next_instr(n, a);
            n++;
        end
        repeat (5) step();
        checks++; if (ret_cnt !== 32'd3) begin errors++; $display("FAIL perf_ret got %0d exp 3", ret_cnt); end
        checks++; if (cyc_cnt !== 32'(ncyc)) begin errors++; $display("FAIL perf_cyc got %0d exp %0d", cyc_cnt, ncyc); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        test_reset();
        test_alu_mem();
        test_wait_states();
        test_branch();
        test_jump();
        test_illegal();
        test_reset_mid_access();
`ifdef MIPS_MC_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
